// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// One shared datapath sweeps all neurons, one per clock, per step.
module lif_array #(
    parameter int N_NEURONS   = 8,
    parameter int WIDTH       = 8,
    parameter int REFRAC_BITS = 2,
    parameter bit RESET_SUB   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             current,
    input  logic                         step,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [REFRAC_BITS-1:0]       refrac,
    input  logic                         beta_we,
    input  logic [$clog2(N_NEURONS)-1:0] beta_addr,
    input  logic [WIDTH-1:0]             beta_data,
    input  logic [$clog2(N_NEURONS)-1:0] state_sel,
    output logic [N_NEURONS-1:0]         spike,
    output logic                         spike_valid,
    output logic                         busy,
    output logic [WIDTH-1:0]             state
);
    localparam int AW = $clog2(N_NEURONS);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} fsm_e;

    fsm_e                   fsm_q, fsm_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [WIDTH-1:0]       cur_q, cur_d;
    logic [WIDTH-1:0]       thr_q, thr_d;
    logic [REFRAC_BITS-1:0] ref_q, ref_d;

    logic [WIDTH-1:0]       u_q    [N_NEURONS];
    logic [WIDTH-1:0]       u_d    [N_NEURONS];
    logic [WIDTH-1:0]       beta_q [N_NEURONS];
    logic [WIDTH-1:0]       beta_d [N_NEURONS];
    logic [REFRAC_BITS-1:0] r_q    [N_NEURONS];
    logic [REFRAC_BITS-1:0] r_d    [N_NEURONS];

    logic [N_NEURONS-1:0]   shadow_q, shadow_d;
    logic [N_NEURONS-1:0]   spike_q, spike_d;
    logic                   spike_valid_q, spike_valid_d;
    logic                   busy_q, busy_d;
    logic [WIDTH-1:0]       state_q, state_d;

    logic [WIDTH-1:0]       u_cur, beta_cur;
    logic [REFRAC_BITS-1:0] r_cur;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH:0]       sum_full;
    logic [WIDTH-1:0]       sum;
    logic                   fire;
    logic [WIDTH-1:0]       new_u;
    logic [REFRAC_BITS-1:0] new_r;
    logic                   new_spk;

    // Shared neuron datapath; sum is kept wide so saturation sees every carry.
    always_comb begin
        u_cur    = u_q[idx_q];
        beta_cur = beta_q[idx_q];
        r_cur    = r_q[idx_q];
        prod     = {{WIDTH{1'b0}}, u_cur} * {{WIDTH{1'b0}}, beta_cur};
        sum_full = {1'b0, prod >> WIDTH} + {{(WIDTH+1){1'b0}}, cur_q};
        sum      = (|sum_full[2*WIDTH:WIDTH]) ? '1 : sum_full[WIDTH-1:0];
        fire     = (sum >= thr_q);
        new_u    = sum;
        new_r    = r_cur;
        new_spk  = 1'b0;
        if (r_cur != '0) begin
            new_u = '0;
            new_r = r_cur - 1'b1;
        end else if (fire) begin
            new_u   = RESET_SUB ? (sum - thr_q) : '0;
            new_r   = ref_q;
            new_spk = 1'b1;
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        idx_d         = idx_q;
        cur_d         = cur_q;
        thr_d         = thr_q;
        ref_d         = ref_q;
        u_d           = u_q;
        r_d           = r_q;
        beta_d        = beta_q;
        shadow_d      = shadow_q;
        spike_d       = spike_q;
        spike_valid_d = 1'b0;
        busy_d        = busy_q;
        state_d       = u_q[state_sel];
        if (beta_we) begin
            beta_d[beta_addr] = beta_data;
        end
        unique case (fsm_q)
            IDLE: begin
                if (step) begin
                    cur_d  = current;
                    thr_d  = threshold;
                    ref_d  = refrac;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    fsm_d  = SWEEP;
                end
            end
            SWEEP: begin
                u_d[idx_q]      = new_u;
                r_d[idx_q]      = new_r;
                shadow_d[idx_q] = new_spk;
                if (idx_q == AW'(N_NEURONS - 1)) begin
                    fsm_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                spike_d       = shadow_q;
                spike_valid_d = 1'b1;
                busy_d        = 1'b0;
                fsm_d         = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= IDLE;
            idx_q         <= '0;
            cur_q         <= '0;
            thr_q         <= '0;
            ref_q         <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                u_q[i]    <= '0;
                r_q[i]    <= '0;
                beta_q[i] <= '1;
            end
            shadow_q      <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= '0;
        end else begin
            fsm_q         <= fsm_d;
            idx_q         <= idx_d;
            cur_q         <= cur_d;
            thr_q         <= thr_d;
            ref_q         <= ref_d;
            u_q           <= u_d;
            r_q           <= r_d;
            beta_q        <= beta_d;
            shadow_q      <= shadow_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            busy_q        <= busy_d;
            state_q       <= state_d;
        end
    end

    assign spike       = spike_q;
    assign spike_valid = spike_valid_q;
    assign busy        = busy_q;
    assign state       = state_q;
endmodule

// File: doc/lif_array.md
# lif_array

Parametrised, time-multiplexed array of leaky integrate-and-fire neurons. One shared decay/integrate/fire datapath sweeps N neurons, one neuron per clock, per input step. Each neuron has a programmable decay factor (beta), a shared firing threshold, a selectable reset mode and a refractory period. The block replaces hard-wired single-neuron instances in the top-level tile. The spike vector drives the bidirectional pins, and a selectable membrane value drives the dedicated outputs.

## Interface
Parameters:
- N_NEURONS, 8: neuron count (2..32).
- WIDTH, 8: membrane, current, beta and threshold width.
- REFRAC_BITS, 2: width of the refractory counter.
- RESET_SUB, 0: after a spike, 0 = membrane cleared to zero; 1 = membrane minus threshold.

Ports:
- clk, in, 1: single clock, all logic on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- current, in, WIDTH: shared input current. Sampled when a step is accepted.
- step, in, 1: request one time-step for all neurons.
- threshold, in, WIDTH: firing threshold. Sampled when a step is accepted.
- refrac, in, REFRAC_BITS: refractory length in steps. Sampled when a step is accepted.
- beta_we, in, 1: beta write strobe.
- beta_addr, in, clog2(N_NEURONS): neuron index for the beta write.
- beta_data, in, WIDTH: beta value to write.
- state_sel, in, clog2(N_NEURONS): selects which membrane appears on `state`.
- spike, out, N_NEURONS: spike vector of the last completed step.
- spike_valid, out, 1: one-cycle pulse when `spike` updates.
- busy, out, 1: high while a sweep is in progress.
- state, out, WIDTH: registered membrane value of neuron `state_sel`.

## Operation
- Storage: per neuron, membrane u[i] (WIDTH bits), beta[i] (WIDTH bits) and refractory counter r[i] (REFRAC_BITS).
- Reset values: u = 0, r = 0, beta = all-ones, spike = 0, spike_valid = 0, busy = 0, state = 0, FSM in IDLE.
- FSM states:
  - IDLE: when step = 1, latch current, threshold and refrac; set index i = 0; go to SWEEP.
  - SWEEP: process neuron i. If i = N_NEURONS-1, go to DONE; otherwise i = i + 1.
  - DONE: commit the spike vector, pulse spike_valid, return to IDLE.
- Per-neuron update when r[i] ≠ 0 (refractory):
  - u[i] = 0; r[i] = r[i] - 1; spike bit i = 0.
- Per-neuron update otherwise:
  - decay = (u[i] * beta[i]) >> WIDTH. The product is 2·WIDTH bits; the result is floored.
  - sum = decay + current, computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
  - Fire when sum >= threshold (unsigned compare).
  - On fire: spike bit i = 1; u[i] = 0 (RESET_SUB = 0) or sum - threshold (RESET_SUB = 1); r[i] = latched refrac.
  - No fire: u[i] = sum; spike bit i = 0.
- Spike bits accumulate in a shadow register. `spike` changes only in DONE.
- threshold = 0 fires every non-refractory neuron on every step.
- beta writes are accepted in any state. If a write targets the neuron being processed in the same cycle, the old beta is used and the new value applies from the next step.
- step while busy is ignored, not queued.
- The `state` register loads u[state_sel] every cycle.

## Timing
- Step accepted in cycle T; neuron i is updated at the edge ending cycle T+1+i.
- busy is high from cycle T+1 through T+N_NEURONS+1 (the SWEEP cycles plus the DONE cycle).
- spike and spike_valid update at the edge ending DONE, i.e. in cycle T+N_NEURONS+2. Step latency is N_NEURONS+2 cycles.
- Minimum step-to-step spacing is N_NEURONS+2 cycles; the next step is accepted in cycle T+N_NEURONS+2.
- A beta write lands one cycle after the strobe.
- `state` lags u[state_sel] by one cycle.
- rst_n asserted mid-sweep: all state clears immediately, the partial step is discarded, and no spike_valid is produced.

## Test plan
1. Defaults (N=8, W=8), beta = 255, threshold = 200, refrac = 0, current = 100, three steps → membranes 100, 199, then 255 (saturated) with spike = 0xFF and u = 0. spike_valid pulses exactly 10 cycles after each accepted step.
2. Same as scenario 1 with refrac = 2 → the two steps after the spike give spike = 0x00 and u = 0; integration restarts at 100 on the following step.
3. Write beta[3] = 0, threshold = 150, current = 100 → neuron 3 holds u = 100 and never fires; the other neurons fire on step 2 (199 >= 150).
4. RESET_SUB = 1, threshold = 150, current = 100 → on step 2, 199 fires and the residue is 49. On step 3, floor(49*255/256) = 48, giving u = 148 and no spike.
5. Assert step during busy and on every cycle → steps are accepted only every 10 cycles; spike_valid count equals the accepted-step count.
6. Drop rst_n mid-sweep at i = 4 → all outputs are 0 immediately, and the next step behaves as scenario 1, step 1.
